// File: rtl/segre_core_ctrl.sv
// Segre core multi-cycle sequencer: IF/ID/EX/MEM/WB state register, memory
// request handshakes, writeback gating, memory-wait watchdog and perf counters.

package segre_core_ctrl_pkg;
   typedef enum logic [2:0] {
      IF_STATE  = 3'd0,
      ID_STATE  = 3'd1,
      EX_STATE  = 3'd2,
      MEM_STATE = 3'd3,
      WB_STATE  = 3'd4
   } fsm_state_e;
endpackage

module segre_core_ctrl
   import segre_core_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             halt_i,
   input  logic             imem_ready_i,
   input  logic             dmem_ready_i,
   input  logic             memop_rd_i,
   input  logic             memop_wr_i,
   input  logic             rf_we_i,
   output fsm_state_e       fsm_state_o,
   output logic             imem_req_o,
   output logic             dmem_req_o,
   output logic             wb_rf_we_o,
   output logic             pc_we_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] cycle_o,
   output logic [CNT_W-1:0] instret_o
);

   // Wide enough to hold MEM_TIMEOUT; saturates so a disabled watchdog never wraps to "idle".
   localparam int unsigned      WAIT_W    = $clog2(MEM_TIMEOUT + 2);
   localparam bit               WD_EN     = (MEM_TIMEOUT != 0);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WD_EN ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
   localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

   fsm_state_e        state;
   fsm_state_e        state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              err;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [CNT_W-1:0]  instret_cnt;
   logic              ireq;
   logic              dreq;
   logic              wait_inc;
   logic              timeout;

   // Handshake/enable decode and next-state selection
   always_comb begin
      ireq       = 1'b0;
      dreq       = 1'b0;
      wb_rf_we_o = 1'b0;
      pc_we_o    = 1'b0;
      state_nxt  = state;
      case (state)
         IF_STATE: begin
            ireq = !err && !(halt_i && (wait_cnt == '0));
            if (ireq && imem_ready_i) state_nxt = ID_STATE;
         end
         ID_STATE:  state_nxt = EX_STATE;
         EX_STATE:  state_nxt = (memop_rd_i || memop_wr_i) ? MEM_STATE : WB_STATE;
         MEM_STATE: begin
            dreq = !err;
            if (dreq && dmem_ready_i) state_nxt = WB_STATE;
         end
         WB_STATE: begin
            wb_rf_we_o = rf_we_i && !err;
            pc_we_o    = !err;
            state_nxt  = IF_STATE;
         end
         default:   state_nxt = IF_STATE;
      endcase
      if (err) state_nxt = state;
      wait_inc = (ireq && !imem_ready_i) || (dreq && !dmem_ready_i);
      timeout  = WD_EN && wait_inc && (wait_cnt == WAIT_LAST);
   end

   // State, watchdog and counters; an error freezes everything until reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IF_STATE;
         wait_cnt    <= '0;
         err         <= 1'b0;
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else if (!err) begin
         state     <= state_nxt;
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (state_nxt != state) wait_cnt <= '0;
         else if (wait_inc && (wait_cnt != WAIT_MAX)) wait_cnt <= wait_cnt + WAIT_W'(1);
         if (timeout) err <= 1'b1;
         if (state == WB_STATE) instret_cnt <= instret_cnt + CNT_W'(1);
      end
   end

   assign fsm_state_o = state;
   assign imem_req_o  = ireq;
   assign dmem_req_o  = dreq;
   assign mem_err_o   = err;
   assign cycle_o     = cycle_cnt;
   assign instret_o   = instret_cnt;

endmodule

// File: doc/segre_core_ctrl.md
Name: segre_core_ctrl

Overview:
Multi-cycle sequencer for the Segre core; owns the fsm_state_e state register that the IF, ID, EX, MEM and WB stages qualify their register updates with.
Drives instruction- and data-memory request handshakes and gates register-file and PC writes to the writeback cycle.
Provides a bounded memory-wait watchdog with a sticky error flag, plus cycle and retired-instruction counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive unanswered request cycles before error; 0 disables watchdog
CNT_W, 32, width of cycle/instret counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
halt_i  in  1  hold core before next fetch is issued
imem_ready_i  in  1  instruction fetch complete (instr valid this cycle)
dmem_ready_i  in  1  data access complete this cycle
memop_rd_i  in  1  instruction in EX is a load (registered ID output)
memop_wr_i  in  1  instruction in EX is a store (registered ID output)
rf_we_i  in  1  instruction in EX/MEM writes register file
fsm_state_o  out  fsm_state_e  current state (IF_STATE, ID_STATE, EX_STATE, MEM_STATE, WB_STATE)
imem_req_o  out  1  instruction fetch request
dmem_req_o  out  1  data access request
wb_rf_we_o  out  1  register-file write enable (WB only)
pc_we_o  out  1  PC update enable (WB only)
mem_err_o  out  1  sticky watchdog error
cycle_o  out  CNT_W  cycles since reset
instret_o  out  CNT_W  retired instructions since reset

Behaviour:
- Reset (rst_i high, async): state=IF_STATE, wait_cnt=0, mem_err_o=0, cycle_o=0, instret_o=0. While reset is held, imem_req_o=!halt_i and all other outputs are 0.
- Request outputs and write enables are combinational decodes of the state register, err flag and the inputs named below. State and counters are registered.
- IF_STATE:
  - imem_req_o = !err && !(halt_i && wait_cnt==0).
  - If imem_req_o && imem_ready_i -> ID_STATE; otherwise stay.
  - halt_i is honoured only while wait_cnt==0 (no fetch outstanding). Once a request is pending, halt_i is ignored until the fetch completes.
- ID_STATE: exactly 1 cycle -> EX_STATE.
- EX_STATE: exactly 1 cycle. memop_rd_i|memop_wr_i -> MEM_STATE, else -> WB_STATE. memop_rd_i and memop_wr_i both high is treated as a memop.
- MEM_STATE:
  - dmem_req_o = !err.
  - dmem_ready_i -> WB_STATE; otherwise stay.
- WB_STATE: exactly 1 cycle.
  - wb_rf_we_o = rf_we_i && !err.
  - pc_we_o = !err.
  - instret_o += 1 at the closing edge; -> IF_STATE.
- Ready inputs: imem_ready_i outside IF_STATE and dmem_ready_i outside MEM_STATE are ignored.
- Latency: ALU instruction with zero-wait memory takes 4 cycles (IF,ID,EX,WB). Memop with zero-wait memory takes 5 cycles. Each wait cycle adds 1.
- Watchdog:
  - wait_cnt increments each cycle a request (imem or dmem) is high without the matching ready. It clears on any state change.
  - If MEM_TIMEOUT!=0 and an unanswered request cycle occurs with wait_cnt==MEM_TIMEOUT-1, mem_err_o sets at that edge.
  - A ready in the same cycle wins over the timeout.
- Error (mem_err_o=1):
  - State is frozen.
  - imem_req_o, dmem_req_o, wb_rf_we_o and pc_we_o are forced to 0.
  - cycle_o and instret_o stop counting.
  - Cleared only by rst_i.
- cycle_o increments every non-error cycle, including halted cycles. Both counters wrap modulo 2^CNT_W silently.
- A reset asserted mid-transaction (e.g. in MEM with dmem_req_o high) drops requests immediately. A late ready after reset is ignored unless it arrives in the matching state.

Test Plan:
- ALU instr, imem_ready_i high in first IF cycle, memop_rd_i=memop_wr_i=0, rf_we_i=1 -> states IF,ID,EX,WB,IF on 4 consecutive edges. wb_rf_we_o=pc_we_o=1 only in WB cycle; instret_o=1, cycle_o=4.
- Load, memop_rd_i=1, dmem_ready_i asserted on 3rd MEM cycle -> MEM lasts 3 cycles with dmem_req_o=1 throughout, then WB. instret_o=1 after 7 cycles total.
- MEM_TIMEOUT=4, imem_ready_i held 0 -> mem_err_o rises at edge 4. State stays IF_STATE, imem_req_o=0, cycle_o frozen at 4. rst_i pulse clears all outputs to reset values.
- halt_i=1 entering IF -> imem_req_o=0, state holds, cycle_o counts. Then assert halt_i one cycle after a request was issued -> request stays high and the fetch completes.
- rst_i asserted mid-MEM_STATE (dmem_req_o=1), then released, then dmem_ready_i pulsed -> dmem_req_o drops asynchronously, state=IF_STATE, stray ready has no effect, instret_o=0.
- CNT_W=4, 16 back-to-back ALU instructions -> instret_o wraps to 0 and cycle_o wraps every 16 cycles, with no error.
